// File: rtl/isp_fifo_pkg.sv
// isp_fifo_pkg: shared FIFO defaults and count-width helper
package isp_fifo_pkg;
  localparam int DEF_DWIDTH = 16;
  localparam int DEF_AWIDTH = 12;
  function automatic int cnt_w(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_lvl_if.sv
// sync_fifo_lvl_if: write/read handshake, flush and status bundle of the level FIFO
interface sync_fifo_lvl_if import isp_fifo_pkg::*; #(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH
);
  logic              clr;
  logic              we;
  logic [DWIDTH-1:0] di;
  logic              re;
  logic [DWIDTH-1:0] dout;
  logic              dout_vld;
  logic              full;
  logic              empty;
  logic              afull;
  logic              aempty;
  logic [AWIDTH:0]   usedw;
  logic              ovf;
  logic              udf;
  modport master (output clr, we, di, re, input dout, dout_vld, full, empty, afull, aempty, usedw, ovf, udf);
  modport slave  (input clr, we, di, re, output dout, dout_vld, full, empty, afull, aempty, usedw, ovf, udf);
endinterface

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: single-write single-read storage array with asynchronous read, no reset
module sync_fifo_ram #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] wa,
  input  logic [DWIDTH-1:0] wd,
  input  logic [AWIDTH-1:0] ra,
  output logic [DWIDTH-1:0] rd
);
  logic [DWIDTH-1:0] mem [2**AWIDTH];
  assign rd = mem[ra];
  // store the accepted write word
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
endmodule

// File: rtl/sync_fifo_lvl.sv
// sync_fifo_lvl: synchronous FIFO with level flags; define SYNC_FIFO_SHOWAHEAD_EN for zero-latency show-ahead reads
module sync_fifo_lvl import isp_fifo_pkg::*; #(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int AWIDTH    = DEF_AWIDTH,
  parameter int AFULL_TH  = 2**AWIDTH - 4,
  parameter int AEMPTY_TH = 4
) (
  input logic            clk,
  input logic            rst,
  sync_fifo_lvl_if.slave f
);
  localparam int CW = cnt_w(AWIDTH);
  localparam logic [CW-1:0] DEPTH = CW'(2**AWIDTH);
  logic [AWIDTH-1:0] wp, rp;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              ovf, udf, afull, aempty, full, empty, wr_ok, rd_ok;
  logic [DWIDTH-1:0] rd;
  assign full    = cnt == DEPTH;
  assign empty   = cnt == '0;
  assign rd_ok   = f.re & ~empty & ~f.clr;
  assign wr_ok   = f.we & (~full | rd_ok) & ~f.clr;
  assign cnt_nxt = cnt + CW'(wr_ok) - CW'(rd_ok);
  sync_fifo_ram #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_ram (
    .clk(clk), .we(wr_ok), .wa(wp), .wd(f.di), .ra(rp), .rd(rd)
  );
  // pointers, count, threshold flags and sticky error flags
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0; rp <= '0; cnt <= '0;
      ovf <= 1'b0; udf <= 1'b0; afull <= 1'b0; aempty <= 1'b1;
    end else if (f.clr) begin
      wp <= '0; rp <= '0; cnt <= '0;
      ovf <= 1'b0; udf <= 1'b0; afull <= 1'b0; aempty <= 1'b1;
    end else begin
      wp     <= wp + AWIDTH'(wr_ok);
      rp     <= rp + AWIDTH'(rd_ok);
      cnt    <= cnt_nxt;
      ovf    <= ovf | (f.we & ~wr_ok);
      udf    <= udf | (f.re & empty);
      afull  <= cnt_nxt >= CW'(AFULL_TH);
      aempty <= cnt_nxt <= CW'(AEMPTY_TH);
    end
`ifdef SYNC_FIFO_SHOWAHEAD_EN
  assign f.dout     = rd;
  assign f.dout_vld = ~empty;
`else
  logic [DWIDTH-1:0] dout_q;
  logic              vld_q;
  // register the read word one cycle after an accepted read
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      dout_q <= '0; vld_q <= 1'b0;
    end else begin
      vld_q <= rd_ok;
      if (rd_ok) dout_q <= rd;
    end
  assign f.dout     = dout_q;
  assign f.dout_vld = vld_q;
`endif
  assign f.full   = full;
  assign f.empty  = empty;
  assign f.afull  = afull;
  assign f.aempty = aempty;
  assign f.usedw  = cnt;
  assign f.ovf    = ovf;
  assign f.udf    = udf;
endmodule

// File: doc/sync_fifo_lvl.md
SYNC_FIFO_LVL -- requirements
Module: sync_fifo_lvl

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, data width in bits.
REQ-002 SHALL have parameter AWIDTH, default 12, address width; depth = 2**AWIDTH words, all usable.
REQ-003 SHALL have parameter AFULL_TH, default 2**AWIDTH-4, almost-full threshold in words.
REQ-004 SHALL have parameter AEMPTY_TH, default 4, almost-empty threshold in words.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port clr  input  1  synchronous flush, active-high.
REQ-008 SHALL have port we  input  1  write request.
REQ-009 SHALL have port di  input  DWIDTH  write data.
REQ-010 SHALL have port re  input  1  read request.
REQ-011 SHALL have port dout  output  DWIDTH  read data.
REQ-012 SHALL have port dout_vld  output  1  dout holds a valid read word.
REQ-013 SHALL have port full / empty  output  1 each  occupancy flags.
REQ-014 SHALL have port afull / aempty  output  1 each  threshold flags.
REQ-015 SHALL have port usedw  output  AWIDTH+1  current word count, 0..2**AWIDTH.
REQ-016 SHALL have port ovf / udf  output  1 each  sticky overflow / underflow flags.

Function
REQ-017 SHALL accept a write when we=1 and (full=0 or an accepted read occurs in the same cycle).
REQ-018 SHALL accept a read when re=1 and empty=0; a read on empty SHALL be ignored and set udf.
REQ-019 SHALL set ovf on a write that is not accepted; no pointer or memory change.
REQ-020 SHALL, for accepted write plus accepted read, advance both pointers and leave usedw unchanged, including at full.
REQ-021 SHALL, on empty with we=1 and re=1, accept the write only, set udf, and increment usedw.
REQ-022 SHALL derive full = (usedw == 2**AWIDTH) and empty = (usedw == 0) from the registered count, with wrap-around pointers of AWIDTH bits.
REQ-023 SHALL assert afull when usedw >= AFULL_TH and aempty when usedw <= AEMPTY_TH, both registered and consistent with usedw in the same cycle.
REQ-024 SHALL, in default mode, register dout one cycle after an accepted read and pulse dout_vld for exactly that cycle; dout holds its value otherwise.
REQ-025 SHALL, when clr=1, reset pointers, usedw, ovf, udf and dout_vld next cycle, ignore we/re in that cycle, and leave memory contents undefined.
REQ-026 SHALL keep ovf/udf set until clr or reset.

Reset
REQ-027 SHALL, on rst=0, asynchronously force usedw=0, empty=1, full=0, aempty=1, afull=0, ovf=0, udf=0, dout_vld=0, dout=0, pointers=0.
REQ-028 SHALL, on reset asserted mid-operation, discard all stored words; first write after release goes to address 0.

Configuration
REQ-029 SHALL, with SYNC_FIFO_SHOWAHEAD_EN defined, present dout = memory[read pointer] combinationally and dout_vld = ~empty, the accepted read acting as acknowledge (zero latency).
REQ-030 SHALL, without SYNC_FIFO_SHOWAHEAD_EN, behave per REQ-024 (one-cycle registered read).

Structure
REQ-031 SHALL place default DWIDTH/AWIDTH constants and a count-width function (AWIDTH+1) in shared package isp_fifo_pkg.
REQ-032 SHALL implement storage in one sub-module sync_fifo_ram (single write port, single read port, no reset on array); control in the top.

Verification
REQ-033 Reset then write 3 words 0x0011,0x0022,0x0033 -> usedw=3, empty=0, aempty=1; three reads return same order, dout_vld one cycle after each re.
REQ-034 AWIDTH=3: write 8 words -> full=1, usedw=8, afull=1; 9th write -> ovf=1, usedw stays 8, data unchanged.
REQ-035 AWIDTH=3 full: we=1,re=1 same cycle with di=0xABCD -> usedw stays 8, oldest word output, 0xABCD read last.
REQ-036 Empty: re=1 alone -> udf=1, dout_vld=0; we=1,re=1 with di=0x0055 -> usedw=1, udf stays 1.
REQ-037 usedw=5 with ovf=1: pulse clr with we=1 -> next cycle usedw=0, empty=1, ovf=0, write discarded.
REQ-038 Assert rst=0 mid-burst at usedw=6 -> outputs at reset values immediately, not waiting for clk; after release write 0x0077 and read -> 0x0077.
